// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer for the 8-bit event counter: owns count, limit and
// prescaler, and steps the count toward the limit every DIV enabled cycles.
module counter_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic [WIDTH-1:0] cnt_q,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_PAUSE = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] limit_r;
  logic [PW-1:0]    presc_r;
  logic [WIDTH-1:0] step_s;

  assign step_s    = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
  assign cmd_ready = ena;
  assign busy      = (state_r == ST_RUN) || (state_r == ST_PAUSED);

  // Sequencer FSM, count/limit/prescaler datapath and registered tick/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_q   <= {WIDTH{1'b0}};
      limit_r <= {WIDTH{1'b0}};
      presc_r <= {PW{1'b0}};
      tick    <= 1'b0;
      done    <= 1'b0;
    end else if (!ena) begin
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      // An accepted command always wins over a pending step on the same edge.
      if (cmd_valid) begin
        case (cmd_op)
          OP_LOAD: begin
            cnt_q   <= cmd_arg;
            presc_r <= {PW{1'b0}};
            state_r <= ST_IDLE;
            done    <= 1'b0;
          end
          OP_START: begin
            limit_r <= cmd_arg;
            presc_r <= {PW{1'b0}};
            if (cmd_arg == cnt_q) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              done    <= 1'b0;
            end
          end
          OP_PAUSE: begin
            case (state_r)
              ST_RUN:    state_r <= ST_PAUSED;
              ST_PAUSED: state_r <= ST_RUN;
              default:   state_r <= state_r;
            endcase
          end
          OP_CLEAR: begin
            state_r <= ST_IDLE;
            cnt_q   <= {WIDTH{1'b0}};
            limit_r <= {WIDTH{1'b0}};
            presc_r <= {PW{1'b0}};
            done    <= 1'b0;
          end
          default: state_r <= state_r;
        endcase
      end else if (state_r == ST_RUN) begin
        if (presc_r == PRE_LAST) begin
          presc_r <= {PW{1'b0}};
          cnt_q   <= step_s;
          tick    <= 1'b1;
          if (step_s == limit_r) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end else begin
          presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Command-driven sequencer for the team's 8-bit event counter datapath. It accepts load, start, pause and clear commands over a valid/ready handshake and owns the counter value, terminal limit and prescaler. It runs the counter from its current value to the limit and reports progress through busy, tick and done. It sits between the tile's dedicated inputs (the command source) and the outputs (count display and status).

Parameters:
WIDTH, 8, counter and limit width in bits
DIV, 4, clock cycles per count step; legal range is DIV >= 1, and DIV=1 steps every cycle

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset; one clock, and no other clock or reset
ena  in  1  design-enable; when low, all state is frozen
cmd_valid  in  1  command present
cmd_ready  out  1  command can be accepted
cmd_op  in  2  0=LOAD, 1=START, 2=PAUSE, 3=CLEAR
cmd_arg  in  WIDTH  LOAD value or START limit
cnt_q  out  WIDTH  current count, registered
busy  out  1  state is RUN or PAUSED
tick  out  1  one-cycle pulse, high during the cycle cnt_q shows a newly stepped value
done  out  1  count reached the limit; sticky

Behaviour:
- Reset (async assert, takes effect without a clock edge):
  - cnt_q=0, limit=0, prescaler=0, state=IDLE.
  - tick=0, done=0, busy=0.
- States: IDLE, RUN, PAUSED, DONE. Encoding is free; the state is not an output.
- cmd_ready = ena. A command is accepted when cmd_valid & cmd_ready at a rising edge. Its effect is visible on the next cycle.
- ena=0:
  - No state, counter or prescaler change.
  - tick is forced to 0 and cmd_ready=0.
  - Outputs hold their values.
- LOAD (any state):
  - cnt_q<=cmd_arg, prescaler<=0, state<=IDLE, done<=0.
  - limit is unchanged.
- START (any state):
  - limit<=cmd_arg, prescaler<=0, done<=0.
  - If cmd_arg==cnt_q: state<=DONE and done<=1 at the same edge, with no tick.
  - Otherwise state<=RUN.
- PAUSE:
  - RUN->PAUSED, and PAUSED->RUN (toggle).
  - Ignored in IDLE and DONE.
  - The prescaler holds its value while PAUSED. After resume, the next step lands after the remaining cycles of the interrupted interval.
- CLEAR (any state): same as reset, applied synchronously.
- RUN:
  - The prescaler counts 0..DIV-1.
  - At the edge where prescaler==DIV-1: prescaler<=0, cnt_q<=cnt_q+1 modulo 2^WIDTH (255->0 wraps and counting continues), tick<=1.
  - On all other edges tick<=0.
  - If the stepped value equals limit: state<=DONE and done<=1 at that same edge.
- Step latency: START accepted at edge k gives first step at edge k+DIV, and step n at edge k+n*DIV.
- DONE:
  - cnt_q holds and done stays high until the next accepted command.
  - busy=0.
- Simultaneous accepted command and prescaler terminal in RUN:
  - The command wins.
  - The step is discarded and tick=0 that cycle.
- tick and done are registered. busy is decoded from registered state.
- Reset asserted mid-RUN or mid-PAUSED aborts the run with no further ticks.

Test Plan:
1. Assert rst for 3 cycles with ena=1 -> cnt_q=0, busy=0, done=0, tick=0, cmd_ready=1. Assert rst between edges -> outputs clear before the next edge.
2. DIV=4: LOAD 5, then START 8 accepted at edge k -> cnt_q=6/7/8 at edges k+4/k+8/k+12. Exactly 3 tick pulses, done=1 from edge k+12, busy falls at edge k+12.
3. LOAD 254, START 1 -> cnt_q sequence 255, 0, 1, then DONE. No early done at 0.
4. LOAD 0, START 10, PAUSE after 6 cycles (cnt_q=1, prescaler=2), wait 20 cycles, PAUSE again -> cnt_q stays 1 and busy=1 while paused. Next step lands 2 cycles after resume (prescaler resumes at 2, steps at DIV-1=3); done at cnt_q=10.
5. LOAD 7, START 7 -> done=1 and busy=0 on the next cycle, no tick. A following LOAD 3 clears done.
6. ena=0 for 10 cycles mid-RUN while cmd_valid=1 -> cnt_q and prescaler frozen, cmd_ready=0, no command consumed. Also: CLEAR accepted on the prescaler-terminal edge -> cnt_q=0, no tick.
